// File: rtl/commutator_sched.sv
// Flow-controlled round-robin commutator: one valid/ready input stream is dealt
// in strict channel order across NCH one-deep output registers, skipping masked channels.
module commutator_sched #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NCH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [NCH-1:0]         ch_en,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_data,
  output logic [NCH-1:0]         m_valid,
  input  logic [NCH-1:0]         m_ready,
  output logic [WIDTH-1:0]       m_data [NCH],
  output logic [$clog2(NCH)-1:0] cur_ch,
  output logic                   rot_done
);

  localparam int unsigned PW = $clog2(NCH);

  logic [PW-1:0]  ptr;
  logic [PW-1:0]  target;
  logic [PW-1:0]  idx;
  logic [PW-1:0]  hi_ch;
  logic [PW-1:0]  ptr_nxt;
  logic           found;
  logic [NCH-1:0] slot_free;
  logic [NCH-1:0] load_mask;
  logic [NCH-1:0] m_valid_nxt;
  logic           accept;

  // First enabled channel at or after ptr, wrapping; busy enabled channels are never skipped.
  always_comb begin
    target = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = PW'((32'(ptr) + k) % NCH);
      if (!found && ch_en[idx]) begin
        target = idx;
        found  = 1'b1;
      end
    end
  end

  // Highest enabled channel marks the end of a rotation.
  always_comb begin
    hi_ch = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_en[i]) hi_ch = PW'(i);
    end
  end

  assign cur_ch    = target;
  assign slot_free = ~m_valid | m_ready;
  assign s_ready   = (|ch_en) && slot_free[target] && !clr;
  assign accept    = s_valid && s_ready;
  assign ptr_nxt   = (target == PW'(NCH - 1)) ? '0 : target + PW'(1);
  assign load_mask = accept ? (NCH'(1) << target) : '0;

  // A same-cycle reload wins over the drain of that slot.
  assign m_valid_nxt = (m_valid & ~m_ready) | load_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      m_valid  <= '0;
      rot_done <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) m_data[i] <= '0;
    end else if (clr) begin
      ptr      <= '0;
      m_valid  <= '0;
      rot_done <= 1'b0;
    end else begin
      m_valid  <= m_valid_nxt;
      rot_done <= accept && (target == hi_ch);
      if (accept) begin
        ptr            <= ptr_nxt;
        m_data[target] <= s_data;
      end
    end
  end

endmodule
